// File: rtl/sccb_target_model.sv
// SCCB/I2C target: decodes START/STOP/address/sub-address/data and serves an 8-bit register file.
// Latency: pins reach the decoder 3 clks late; SDA drive changes HOLD_CYC clks after a seen SCL fall.
// Backpressure: none; the bus master owns timing, and wr_valid is a one-cycle pulse with no ready.
module sccb_target_model #(
    parameter logic [6:0] DEV_ADDR = 7'h30,
    parameter int         REG_AW   = 6,
    parameter int         HOLD_CYC = 4,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic              loc_wr_en,
    input  logic [REG_AW-1:0] loc_addr,
    input  logic [7:0]        loc_data,
    output logic              wr_valid,
    output logic [7:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [2:0] {
        IDLE, DEVADDR, ACK, SUBADDR, WR_DATA, RD_DATA, MACK, IGNORE
    } state_t;

    // Read-only ID bytes live at 0x0A/0x0B and are never overwritten.
    function automatic logic is_id(input logic [7:0] a);
        return (a == 8'h0A) || (a == 8'h0B);
    endfunction

    function automatic logic in_range(input logic [7:0] a);
        return (a >> REG_AW) == 8'd0;
    endfunction

    logic       scl_s1_q, scl_s2_q, scl_h_q;
    logic       sda_s1_q, sda_s2_q, sda_h_q;
    logic       scl_rise, scl_fall, start_evt, stop_evt, drive_evt;
    state_t     state_q, state_d, ack_nxt_q, ack_nxt_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, ptr_q, ptr_d, hold_q, hold_d;
    logic       oe_q, oe_d, busy_q, busy_d, wr_vld_q, wr_vld_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic       bus_we;
    logic [7:0] byte_in, ptr_inc, rd_cur, rd_inc;
    logic [7:0] regs_q [NREG];

    // Two-flop synchronisers plus a history stage; idle bus level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
        end else begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= {scl_in, scl_s1_q, scl_s2_q};
            {sda_s1_q, sda_s2_q, sda_h_q} <= {sda_in, sda_s1_q, sda_s2_q};
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_evt = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_evt  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    // Drive updates only late in the SCL low phase, and never once SCL is seen high again.
    assign drive_evt = (hold_q == 8'd1) & ~scl_s2_q;

    assign byte_in = {shift_q[6:0], sda_s2_q};
    assign ptr_inc = AUTO_INC ? ptr_q + 8'd1 : ptr_q;
    assign rd_cur  = in_range(ptr_q)   ? regs_q[ptr_q[REG_AW-1:0]]   : 8'h00;
    assign rd_inc  = in_range(ptr_inc) ? regs_q[ptr_inc[REG_AW-1:0]] : 8'h00;

    // Next-state: bus events first, then bit handling on SCL rise, then SDA drive scheduling.
    always_comb begin
        state_d   = state_q;
        ack_nxt_d = ack_nxt_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bus_we    = 1'b0;
        hold_d    = scl_fall ? 8'(HOLD_CYC) : ((hold_q != 8'd0) ? hold_q - 8'd1 : 8'd0);

        if (stop_evt) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            hold_d  = 8'd0;
        end else if (start_evt) begin
            state_d = DEVADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (scl_rise) begin
            unique case (state_q)
                DEVADDR, SUBADDR, WR_DATA: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ACK;
                        if (state_q == DEVADDR) begin
                            if (byte_in[7:1] == DEV_ADDR)
                                ack_nxt_d = byte_in[0] ? RD_DATA : SUBADDR;
                            else
                                state_d = IGNORE;
                        end else if (state_q == SUBADDR) begin
                            ptr_d     = byte_in;
                            ack_nxt_d = WR_DATA;
                        end else begin
                            bus_we    = in_range(ptr_q) && !is_id(ptr_q);
                            wr_vld_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = byte_in;
                            ptr_d     = ptr_inc;
                            ack_nxt_d = WR_DATA;
                        end
                    end
                end
                ACK: begin
                    state_d = ack_nxt_q;
                    cnt_d   = 3'd0;
                    if (ack_nxt_q == RD_DATA) shift_d = rd_cur;
                end
                RD_DATA: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = MACK;
                end
                MACK: begin
                    cnt_d = 3'd0;
                    if (!sda_s2_q) begin
                        ptr_d   = ptr_inc;
                        shift_d = rd_inc;
                        state_d = RD_DATA;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                default: ;
            endcase
        end else if (drive_evt) begin
            unique case (state_q)
                ACK:     oe_d = 1'b1;
                RD_DATA: oe_d = ~shift_q[7];
                default: oe_d = 1'b0;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ack_nxt_q <= IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 8'h00;
            hold_q    <= 8'd0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ack_nxt_q <= ack_nxt_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file: local preload port, with a same-cycle bus write to the same entry winning.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
            regs_q[10] <= 8'h26;
            regs_q[11] <= 8'h42;
        end else begin
            if (loc_wr_en && !is_id(8'(loc_addr))) regs_q[loc_addr] <= loc_data;
            if (bus_we) regs_q[ptr_q[REG_AW-1:0]] <= byte_in;
        end
    end

    assign sda_oe   = oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_vld_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
endmodule

// File: tb/tb_sccb_target_model.sv
// Bench for sccb_target_model: a bit-banged bus master plus a transaction-level register model.
// The model tracks register contents, the sub-address pointer and the expected write-notify pulses.
module tb_sccb_target_model;
    localparam logic [6:0] DEV = 7'h30;
    localparam int         TQ  = 10;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       loc_wr_en = 1'b0;
    logic [5:0] loc_addr = 6'd0;
    logic [7:0] loc_data = 8'h00;
    logic       scl_in, sda_in, sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;

    // Open-drain bus: either side can pull SDA low.
    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    sccb_target_model dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .loc_wr_en(loc_wr_en), .loc_addr(loc_addr), .loc_data(loc_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0, miscompares = 0;
    logic [7:0]  mreg [256];
    logic [7:0]  mptr;
    logic [15:0] exp_q [$];
    logic [15:0] last_wr;
    logic        oe_seen, oe_prev;
    logic [7:0]  wdat [8];
    logic [7:0]  rdat [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wq();
        wc(TQ);
    endtask

    // ---- behavioural register model ----
    task automatic model_reset();
        for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
        mreg[10] = 8'h26;
        mreg[11] = 8'h42;
        mptr = 8'h00;
        exp_q.delete();
    endtask

    function automatic logic writable(input logic [7:0] a);
        return (a < 8'd64) && (a != 8'h0A) && (a != 8'h0B);
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return (a < 8'd64) ? mreg[a] : 8'h00;
    endfunction

    // ---- compare process: write-notify pulses and SDA drive timing, every cycle ----
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (sda_oe) oe_seen = 1'b1;
                if (sda_oe !== oe_prev) chk("oe_change_while_scl_high", 32'(scl_in), 32'd0);
                if (wr_valid) begin
                    last_wr = {wr_addr, wr_data};
                    if (exp_q.size() == 0) chk("wr_valid_unexpected", 32'({wr_addr, wr_data}), 32'hFFFFFFFF);
                    else chk("wr_pulse_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
                end
            end
            oe_prev = sda_oe;
        end
    endtask

    // ---- bus master ----
    task automatic bus_start();
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; wq(); scl_m = 1'b1; wq(); scl_m = 1'b0; wq();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wq(); scl_m = 1'b1; wc(TQ / 2); b = sda_in; wc(TQ / 2); scl_m = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(nack);
    endtask

    // Write transaction: address, sub-address, n data bytes from wdat[], STOP.
    task automatic wr_txn(input logic [6:0] a7, input logic [7:0] sub, input int n);
        logic ack;
        logic hit;
        hit = (a7 == DEV);
        oe_seen = 1'b0;
        bus_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        send_byte({a7, 1'b0}, ack);
        chk("ack_wr_addr", 32'(ack), 32'(!hit));
        send_byte(sub, ack);
        chk("ack_subaddr", 32'(ack), 32'(!hit));
        if (hit) mptr = sub;
        for (int k = 0; k < n; k++) begin
            if (hit) begin
                exp_q.push_back({mptr, wdat[k]});
                if (writable(mptr)) mreg[mptr] = wdat[k];
                mptr = mptr + 8'd1;
            end
            send_byte(wdat[k], ack);
            chk("ack_wr_data", 32'(ack), 32'(!hit));
        end
        bus_stop();
        wc(4);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("wr_pulses_outstanding", 32'(exp_q.size()), 32'd0);
        if (!hit) chk("foreign_addr_never_drives", 32'(oe_seen), 32'd0);
    endtask

    // Read transaction: optional sub-address set (repeated START or STOP+START), n bytes, NACK last.
    task automatic rd_txn(input logic set_sub, input logic [7:0] sub, input logic rep, input int n);
        logic ack;
        logic [7:0] got;
        if (set_sub) begin
            bus_start();
            send_byte({DEV, 1'b0}, ack);
            chk("ack_rd_setup_addr", 32'(ack), 32'd0);
            send_byte(sub, ack);
            chk("ack_rd_subaddr", 32'(ack), 32'd0);
            mptr = sub;
            if (!rep) bus_stop();
        end
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        chk("ack_rd_addr", 32'(ack), 32'd0);
        for (int k = 0; k < n; k++) begin
            recv_byte(got, k == n - 1);
            chk("rd_byte", 32'(got), 32'(model_rd(mptr)));
            rdat[k] = got;
            if (k != n - 1) mptr = mptr + 8'd1;
        end
        chk("busy_before_stop", 32'(busy), 32'd1);
        bus_stop();
        wc(4);
        chk("busy_after_rd_stop", 32'(busy), 32'd0);
    endtask

    task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
        loc_addr = a; loc_data = d; loc_wr_en = 1'b1;
        wc(1);
        loc_wr_en = 1'b0;
        if (writable(8'(a))) mreg[a] = d;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic       ack, b;
        logic [7:0] sub;
        logic [6:0] a7;
        int         n, op;
        model_reset();
        oe_prev = 1'b0;
        wc(3);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        wc(4);
        fork monitor(); join_none

        // Write then read back through STOP/START.
        wdat[0] = 8'h80;
        wr_txn(DEV, 8'h12, 1);
        chk("lit_wr_pulse_1280", 32'(last_wr), 32'h1280);
        rd_txn(1'b1, 8'h12, 1'b0, 1);
        chk("lit_readback_80", 32'(rdat[0]), 32'h80);

        // ID registers with repeated START and auto-increment.
        rd_txn(1'b1, 8'h0A, 1'b1, 2);
        chk("lit_id0", 32'(rdat[0]), 32'h26);
        chk("lit_id1", 32'(rdat[1]), 32'h42);

        // Foreign device address.
        wdat[0] = 8'hA5; wdat[1] = 8'h5A;
        wr_txn(7'h21, 8'h12, 2);

        // Writes to ID registers notify but do not stick.
        wdat[0] = 8'h55;
        wr_txn(DEV, 8'h0A, 1);
        chk("lit_wr_pulse_0a55", 32'(last_wr), 32'h0A55);
        rd_txn(1'b1, 8'h0A, 1'b1, 1);
        chk("lit_id_kept", 32'(rdat[0]), 32'h26);

        // STOP after 5 bits of a data byte discards it.
        wdat[0] = 8'h99;
        wr_txn(DEV, 8'h20, 1);
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        chk("ack_partial_addr", 32'(ack), 32'd0);
        send_byte(8'h20, ack);
        chk("ack_partial_sub", 32'(ack), 32'd0);
        mptr = 8'h20;
        for (int i = 0; i < 5; i++) put_bit(i[0]);
        bus_stop();
        wc(4);
        chk("partial_oe_released", 32'(sda_oe), 32'd0);
        chk("partial_no_pulse", 32'(exp_q.size()), 32'd0);
        rd_txn(1'b1, 8'h20, 1'b1, 1);
        chk("lit_partial_unchanged", 32'(rdat[0]), 32'h99);
        wdat[0] = 8'h3E;
        wr_txn(DEV, 8'h21, 1);

        // Randomised traffic: writes (incl. pointer wrap and foreign address), reads, local preloads.
        for (int it = 0; it < 16; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: begin
                    sub = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(254, 255)) : 8'($urandom_range(0, 71));
                    n   = int'($urandom_range(1, 3));
                    for (int k = 0; k < 8; k++) wdat[k] = 8'($urandom);
                    a7  = ($urandom_range(0, 7) == 0) ? 7'h21 : DEV;
                    wr_txn(a7, sub, n);
                end
                2: rd_txn(1'b1, 8'($urandom_range(0, 71)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
                3: rd_txn(1'b0, 8'h00, 1'b0, int'($urandom_range(1, 2)));
                default: begin
                    sub = 8'($urandom_range(0, 63));
                    loc_write(sub[5:0], 8'($urandom));
                    rd_txn(1'b1, sub, 1'b1, 1);
                end
            endcase
        end

        // Reset during a read while SDA is driven.
        wdat[0] = 8'h80;
        wr_txn(DEV, 8'h12, 1);
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        send_byte(8'h12, ack);
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        chk("ack_pre_reset", 32'(ack), 32'd0);
        get_bit(b);
        chk("pre_reset_bit7", 32'(b), 32'd1);
        for (int i = 0; i < 40 && !sda_oe; i++) @(posedge clk);
        chk("oe_driven_before_reset", 32'(sda_oe), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("oe_async_release", 32'(sda_oe), 32'd0);
        model_reset();
        wc(3);
        reset_n = 1'b1;
        wc(3);
        bus_stop();
        rd_txn(1'b1, 8'h12, 1'b1, 1);
        chk("lit_post_reset_zero", 32'(rdat[0]), 32'h00);
        loc_write(6'h12, 8'h3C);
        loc_write(6'h0A, 8'h77);
        rd_txn(1'b1, 8'h12, 1'b1, 1);
        chk("lit_local_3c", 32'(rdat[0]), 32'h3C);
        rd_txn(1'b1, 8'h0A, 1'b1, 1);
        chk("lit_local_id_ignored", 32'(rdat[0]), 32'h26);

        wc(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
